// File: rtl/uart_bridge.sv
// uart_bridge
//   Responder end of the parallel UART handshake. Holds one received byte
//   (rx_hold) and one byte waiting to be sent (tx_hold), and runs two
//   independent 8N1 shift engines on txd/rxd.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   UartData   parallel bus; driven with rx_hold during a read (and one
//              cycle after rdn rises), high impedance otherwise
//   rdn, wrn   active-low read/write strobes, synchronous to clk
//   data_ready rx_hold holds an unread byte
//   tbre       tx_hold is empty
//   tsre       transmit shifter idle (line idle)
//   txd        serial output, idle high
//   rxd        serial input, asynchronous
//   err_flags  sticky {tx overrun, rx overrun, framing}
module uart_bridge #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  inout  logic [7:0] UartData,
  input  logic       rdn,
  input  logic       wrn,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd,
  output logic [2:0] err_flags
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------------
  // Strobe edge detection and bus drive
  // ---------------------------------------------------------------------
  logic       rdn_q, wrn_q;
  logic       rd_rise, wr_rise;
  logic [7:0] rx_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdn_q <= 1'b1;
      wrn_q <= 1'b1;
    end else begin
      rdn_q <= rdn;
      wrn_q <= wrn;
    end
  end

  assign rd_rise = !rdn_q && rdn;
  assign wr_rise = !wrn_q && wrn;

  // rdn_q lags rdn by one cycle, which provides the one-cycle read hold.
  assign UartData = (!rdn || !rdn_q) ? rx_hold : 'z;

  // ---------------------------------------------------------------------
  // Transmit holding register
  // ---------------------------------------------------------------------
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic [7:0]    tx_hold;
  logic          tx_load;
  logic          err_txov;

  assign tx_load = !tbre &&
                   ((tx_state == S_IDLE) ||
                    ((tx_state == S_STOP) && (tx_cnt == CNT_LAST)));

  // A write arriving on the same edge as a load sees the buffer as empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbre     <= 1'b1;
      tx_hold  <= '0;
      err_txov <= 1'b0;
    end else if (wr_rise) begin
      if (tbre || tx_load) begin
        tx_hold <= UartData;
        tbre    <= 1'b0;
      end else begin
        err_txov <= 1'b1;
      end
    end else if (tx_load) begin
      tbre <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit engine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      tsre     <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          txd <= 1'b1;
          if (tx_load) begin
            tx_shift <= tx_hold;
            tsre     <= 1'b0;
            txd      <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_load) begin
              // Chain straight into the next frame, no idle bit.
              tx_shift <= tx_hold;
              txd      <= 1'b0;
              tx_state <= S_START;
            end else begin
              tsre     <= 1'b1;
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Receive synchroniser
  // ---------------------------------------------------------------------
  logic rx_meta, rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Receive engine and holding register
  // ---------------------------------------------------------------------
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_brk;
  logic          err_frame, err_rxov;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_brk     <= 1'b0;
      rx_hold    <= '0;
      data_ready <= 1'b0;
      err_frame  <= 1'b0;
      err_rxov   <= 1'b0;
    end else begin
      // A stop-bit accept later in this block overrides the read clear.
      if (rd_rise) data_ready <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rxs) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_state <= S_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= S_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxs, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_brk) begin
            // Line held low after a bad stop bit: wait for it to recover.
            if (rxs) begin
              rx_brk   <= 1'b0;
              rx_state <= S_IDLE;
            end
          end else if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_hold    <= rx_shift;
              data_ready <= 1'b1;
              if (data_ready) err_rxov <= 1'b1;
              rx_state   <= S_IDLE;
            end else begin
              err_frame <= 1'b1;
              rx_brk    <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  assign err_flags = {err_txov, err_rxov, err_frame};

endmodule

// File: tb/tb_uart_bridge.sv
// tb_uart_bridge
//   Directed bench for uart_bridge: reset state, single and chained
//   transmit frames with overrun, receive with read handshake, receive
//   errors, and reset in the middle of traffic.
module tb_uart_bridge;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst, rdn, wrn, rxd, tb_drv;
  logic [7:0] tb_data;
  wire  [7:0] UartData;
  logic       data_ready, tbre, tsre, txd;
  logic [2:0] err_flags;
  int         checks = 0;
  int         errors = 0;
  int         lat;

  always #5 clk = ~clk;

  // Bench side of the bus; pull-ups make a released bus read as 8'hFF.
  assign UartData = tb_drv ? tb_data : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (UartData[g]);
  end

  uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .UartData   (UartData),
    .rdn        (rdn),
    .wrn        (wrn),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .txd        (txd),
    .rxd        (rxd),
    .err_flags  (err_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle write strobe; returns just after the edge that registers it.
  task automatic write_byte(input logic [7:0] b);
    tb_data = b;
    tb_drv  = 1'b1;
    wrn     = 1'b0;
    tick(1);
    wrn     = 1'b1;
    tick(1);
    tb_drv  = 1'b0;
    chk("tbre_after_write", tbre, 1'b0);
  endtask

  // Called 1 ns after the start-bit edge; checks each bit at its midpoint
  // and returns at the stop-bit midpoint.
  task automatic check_frame(input logic [7:0] b);
    tick(CPB / 2);
    chk("tx_start_bit", txd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      chk("tx_data_bit", txd, b[i]);
    end
    tick(CPB);
    chk("tx_stop_bit", txd, 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    rdn     = 1'b1;
    wrn     = 1'b1;
    rxd     = 1'b1;
    tb_drv  = 1'b0;
    tb_data = '0;

    // Reset idle
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("rst_txd", txd, 1'b1);
    chk("rst_tbre", tbre, 1'b1);
    chk("rst_tsre", tsre, 1'b1);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_err", err_flags, 3'b000);
    chk("rst_bus_released", UartData, 8'hFF);

    // Single transmit of 0xA5
    write_byte(8'hA5);
    tick(1);
    chk("tx_tbre_reloaded", tbre, 1'b1);
    chk("tx_start_edge", txd, 1'b0);
    check_frame(8'hA5);
    tick(7);
    chk("tx_tsre_before_end", tsre, 1'b0);
    tick(1);
    chk("tx_tsre_at_160", tsre, 1'b1);
    chk("tx_idle_line", txd, 1'b1);

    // Chained transmit with overrun: 0x41, 0x42 during DATA, 0x43 rejected
    tick(4);
    write_byte(8'h41);
    tick(1);
    fork
      begin
        check_frame(8'h41);
        tick(CPB / 2);
        chk("b2b_no_gap", txd, 1'b0);
        chk("b2b_tsre_busy", tsre, 1'b0);
        check_frame(8'h42);
        tick(CPB / 2);
        chk("b2b_end_txd", txd, 1'b1);
        chk("b2b_end_tsre", tsre, 1'b1);
      end
      begin
        tick(40);
        write_byte(8'h42);
        tick(4);
        write_byte(8'h43);
        chk("tx_overrun_flag", err_flags, 3'b100);
      end
    join
    chk("b2b_tbre_empty", tbre, 1'b1);
    tick(40);
    chk("tx_0x43_not_sent_txd", txd, 1'b1);
    chk("tx_0x43_not_sent_tsre", tsre, 1'b1);

    // Receive 0x3C, then read it
    lat = 0;
    fork
      send_rx(8'h3C, 1'b1);
      begin
        while (!data_ready && lat < 400) begin
          tick(1);
          lat++;
        end
      end
    join
    chk("rx_latency_window", (lat >= 148 && lat <= 160), 1'b1);
    chk("rx_data_ready", data_ready, 1'b1);
    chk("rx_err_clean", err_flags, 3'b100);
    rdn = 1'b0;
    #1;
    chk("rd_bus_low", UartData, 8'h3C);
    tick(1);
    rdn = 1'b1;
    #1;
    chk("rd_bus_hold", UartData, 8'h3C);
    chk("rd_dr_before_edge", data_ready, 1'b1);
    tick(1);
    chk("rd_dr_cleared", data_ready, 1'b0);
    chk("rd_bus_released", UartData, 8'hFF);

    // Glitch on rxd is a false start
    tick(10);
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(40);
    chk("glitch_no_data", data_ready, 1'b0);
    chk("glitch_no_err", err_flags, 3'b100);

    // Bad stop bit
    send_rx(8'h55, 1'b0);
    tick(20);
    chk("frame_err_flag", err_flags, 3'b101);
    chk("frame_err_no_data", data_ready, 1'b0);

    // Two frames without a read: overwrite and overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    tick(4);
    chk("rx_ovr_data_ready", data_ready, 1'b1);
    chk("rx_ovr_flag", err_flags, 3'b111);
    rdn = 1'b0;
    #1;
    chk("rx_ovr_latest_byte", UartData, 8'h22);
    tick(1);
    rdn = 1'b1;
    tick(1);
    chk("rx_ovr_read_clear", data_ready, 1'b0);

    // Reset during TX bit 4 and RX bit 3
    tick(10);
    write_byte(8'h00);
    tick(1);
    fork
      begin
        tick(19);
        send_rx(8'hF0, 1'b1);
      end
      begin
        tick(88);
        chk("pre_rst_tx_bit4", txd, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1'b1);
        chk("mid_rst_tbre", tbre, 1'b1);
        chk("mid_rst_tsre", tsre, 1'b1);
        chk("mid_rst_data_ready", data_ready, 1'b0);
        chk("mid_rst_err", err_flags, 3'b000);
      end
    join
    chk("rst_hold_txd", txd, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(2);
    write_byte(8'h7E);
    tick(1);
    check_frame(8'h7E);
    tick(CPB / 2);
    chk("post_rst_tsre", tsre, 1'b1);
    chk("post_rst_no_rx", data_ready, 1'b0);
    chk("post_rst_err", err_flags, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
